// File: rtl/mw_stage.sv
// Memory/Write-back pipeline register plus write-back logic: load alignment,
// write-back data select and destination decode for the register file.
module mw_stage #(
    parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] IR_M_in,
    input  logic [31:0] ALUout_M_in,
    input  logic [31:0] XALUout_M_in,
    input  logic [31:0] DM_M_in,
    input  logic [31:0] PC8_M_in,
    input  logic [31:0] CP0_M_in,
    output logic [31:0] IR_W_out,
    output logic [31:0] PC8_W_out,
    output logic [31:0] RF_wd,
    output logic [4:0]  RF_wa,
    output logic        RF_we,
    output logic        valid_W
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    typedef enum logic [2:0] {
        SEL_ALU,
        SEL_LOAD,
        SEL_PC8,
        SEL_XALU,
        SEL_CP0
    } wb_sel_t;

    logic [31:0] ir_q, alu_q, xalu_q, dm_q, pc8_q, cp0_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q    <= RESET_IR;
            alu_q   <= '0;
            xalu_q  <= '0;
            dm_q    <= '0;
            pc8_q   <= '0;
            cp0_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            ir_q    <= RESET_IR;
            alu_q   <= '0;
            xalu_q  <= '0;
            dm_q    <= '0;
            pc8_q   <= '0;
            cp0_q   <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            ir_q    <= IR_M_in;
            alu_q   <= ALUout_M_in;
            xalu_q  <= XALUout_M_in;
            dm_q    <= DM_M_in;
            pc8_q   <= PC8_M_in;
            cp0_q   <= CP0_M_in;
            valid_q <= 1'b1;
        end
    end

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];

    logic    writes;
    logic [4:0] wa;
    wb_sel_t sel;

    always_comb begin
        writes = 1'b0;
        wa     = rt;
        sel    = SEL_ALU;
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                writes = 1'b1;
                sel    = SEL_LOAD;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                writes = 1'b1;
            end
            OP_JAL: begin
                writes = 1'b1;
                wa     = 5'd31;
                sel    = SEL_PC8;
            end
            OP_COP0: begin
                // Only mfc0 (rs = 0) writes; mtc0 and eret share this opcode.
                writes = (rs == 5'd0);
                sel    = SEL_CP0;
            end
            OP_RTYPE: begin
                wa = rd;
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: writes = 1'b1;
                    6'h09: begin
                        writes = 1'b1;
                        sel    = SEL_PC8;
                    end
                    6'h10, 6'h12: begin
                        writes = 1'b1;
                        sel    = SEL_XALU;
                    end
                    default: writes = 1'b0;
                endcase
            end
            default: writes = 1'b0;
        endcase
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;

    always_comb begin
        load_byte = dm_q[8*alu_q[1:0] +: 8];
        load_half = alu_q[1] ? dm_q[31:16] : dm_q[15:0];
        case (op)
            OP_LB:   load_val = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_val = {24'd0, load_byte};
            OP_LH:   load_val = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_val = {16'd0, load_half};
            default: load_val = dm_q;
        endcase
    end

    always_comb begin
        case (sel)
            SEL_LOAD: RF_wd = load_val;
            SEL_PC8:  RF_wd = pc8_q;
            SEL_XALU: RF_wd = xalu_q;
            SEL_CP0:  RF_wd = cp0_q;
            default:  RF_wd = alu_q;
        endcase
    end

    assign RF_wa     = wa;
    assign RF_we     = valid_q && writes && (wa != 5'd0);
    assign IR_W_out  = ir_q;
    assign PC8_W_out = pc8_q;
    assign valid_W   = valid_q;

endmodule

// File: tb/tb_mw_stage.sv
// Self-checking bench for mw_stage: directed cases plus randomized traffic
// compared against a transaction-level model of the W slot.
module tb_mw_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] ir_in = '0, alu_in = '0, xalu_in = '0, dm_in = '0, pc8_in = '0, cp0_in = '0;
    logic [31:0] IR_W_out, PC8_W_out, RF_wd;
    logic [4:0]  RF_wa;
    logic        RF_we, valid_W;

    int checks = 0;
    int errors = 0;

    // Model of the W slot: the last accepted transaction.
    logic [31:0] m_ir, m_alu, m_xalu, m_dm, m_pc8, m_cp0;
    logic        m_valid;

    mw_stage dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .IR_M_in(ir_in), .ALUout_M_in(alu_in), .XALUout_M_in(xalu_in),
        .DM_M_in(dm_in), .PC8_M_in(pc8_in), .CP0_M_in(cp0_in),
        .IR_W_out(IR_W_out), .PC8_W_out(PC8_W_out), .RF_wd(RF_wd),
        .RF_wa(RF_wa), .RF_we(RF_we), .valid_W(valid_W)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_ir = 32'h0; m_alu = '0; m_xalu = '0; m_dm = '0; m_pc8 = '0; m_cp0 = '0;
        m_valid = 1'b0;
    endtask

    // Architectural meaning of the held instruction, computed from mnemonics.
    task automatic predict(output logic we, output logic [4:0] wa, output logic [31:0] wd);
        int op, fn, rs, rt, rd, b;
        int unsigned bytev, halfv;
        logic writes;
        op = int'(m_ir[31:26]); fn = int'(m_ir[5:0]);
        rs = int'(m_ir[25:21]); rt = int'(m_ir[20:16]); rd = int'(m_ir[15:11]);
        b  = int'(m_alu[1:0]);
        bytev = (m_dm >> (8 * b)) & 32'hFF;
        halfv = (m_dm >> (16 * (b / 2))) & 32'hFFFF;
        writes = 1'b0; wa = 5'd0; wd = m_alu;
        if (op == 'h23) begin writes = 1; wa = 5'(rt); wd = m_dm; end
        else if (op == 'h20) begin writes = 1; wa = 5'(rt); wd = (bytev >= 128) ? bytev - 256 : bytev; end
        else if (op == 'h24) begin writes = 1; wa = 5'(rt); wd = bytev; end
        else if (op == 'h21) begin writes = 1; wa = 5'(rt); wd = (halfv >= 32768) ? halfv - 65536 : halfv; end
        else if (op == 'h25) begin writes = 1; wa = 5'(rt); wd = halfv; end
        else if (op >= 'h08 && op <= 'h0F) begin writes = 1; wa = 5'(rt); end
        else if (op == 'h03) begin writes = 1; wa = 5'd31; wd = m_pc8; end
        else if (op == 'h10 && rs == 0) begin writes = 1; wa = 5'(rt); wd = m_cp0; end
        else if (op == 0) begin
            if (fn == 'h09) begin writes = 1; wa = 5'(rd); wd = m_pc8; end
            else if (fn == 'h10 || fn == 'h12) begin writes = 1; wa = 5'(rd); wd = m_xalu; end
            else if (fn inside {'h00, 'h02, 'h03, 'h04, 'h06, 'h07}
                     || (fn >= 'h20 && fn <= 'h27) || fn == 'h2A || fn == 'h2B) begin
                writes = 1; wa = 5'(rd);
            end
        end
        we = m_valid && writes && (wa != 5'd0);
    endtask

    task automatic checkAll(input string tag);
        logic we; logic [4:0] wa; logic [31:0] wd;
        predict(we, wa, wd);
        checkOutput({tag, "_ir"}, IR_W_out, m_ir);
        checkOutput({tag, "_pc8"}, PC8_W_out, m_pc8);
        checkOutput({tag, "_valid"}, 32'(valid_W), 32'(m_valid));
        checkOutput({tag, "_we"}, 32'(RF_we), 32'(we));
        if (we) begin
            checkOutput({tag, "_wa"}, 32'(RF_wa), 32'(wa));
            checkOutput({tag, "_wd"}, RF_wd, wd);
        end
    endtask

    // Called just after a falling edge: drives inputs, confirms nothing leaks
    // through combinationally, then checks the result after the rising edge.
    task automatic applyStimulus(input string tag,
                                 input logic [31:0] ir, input logic [31:0] alu,
                                 input logic [31:0] xalu, input logic [31:0] dm,
                                 input logic [31:0] pc8, input logic [31:0] cp0,
                                 input logic e, input logic f);
        ir_in = ir; alu_in = alu; xalu_in = xalu; dm_in = dm; pc8_in = pc8; cp0_in = cp0;
        en = e; flush = f;
        #1;
        checkAll({tag, "_pre"});
        if (f) modelReset();
        else if (e) begin
            m_ir = ir; m_alu = alu; m_xalu = xalu; m_dm = dm; m_pc8 = pc8; m_cp0 = cp0;
            m_valid = 1'b1;
        end
        @(posedge clk); #1;
        checkAll(tag);
        @(negedge clk);
    endtask

    function automatic logic [31:0] randInstr();
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        logic [5:0] fn;
        int k;
        rs = 5'($urandom); imm = 16'($urandom);
        rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        fn = 6'($urandom);
        k = $urandom_range(0, 11);
        case (k)
            0: return {6'h23, rs, rt, imm};
            1: return {6'h20, rs, rt, imm};
            2: return {6'h24, rs, rt, imm};
            3: return {6'h21, rs, rt, imm};
            4: return {6'h25, rs, rt, imm};
            5: return {3'b001, 3'($urandom), rs, rt, imm};
            6: return {6'h03, 26'($urandom)};
            7: return {6'h10, ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd4, rt, rd, 11'd0};
            8: return {6'h00, rs, rt, rd, 5'($urandom), fn};
            9: return {6'h00, rs, rt, rd, 5'd0, 6'h09};
            10: return {6'($urandom_range(0, 63)), 26'($urandom)};
            default: return {6'h2B, rs, rt, imm};
        endcase
    endfunction

    initial begin
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_hold_we", 32'(RF_we), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(valid_W), 32'd0);
        checkOutput("rst_ir", IR_W_out, 32'd0);
        checkOutput("rst_pc8", PC8_W_out, 32'd0);
        checkOutput("rst_wa", 32'(RF_wa), 32'd0);
        checkOutput("rst_wd", RF_wd, 32'd0);
        @(negedge clk);

        applyStimulus("lw", 32'h8C08_0004, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h100, 32'h0, 1, 0);
        checkOutput("lw_wa_k", 32'(RF_wa), 32'd8);
        checkOutput("lw_wd_k", RF_wd, 32'hDEAD_BEEF);
        applyStimulus("lb", 32'h8009_0000, 32'h13, 32'h0, 32'h8000_0000, 32'h104, 32'h0, 1, 0);
        checkOutput("lb_wd_k", RF_wd, 32'hFFFF_FF80);
        applyStimulus("lbu", 32'h9009_0000, 32'h13, 32'h0, 32'h8000_0000, 32'h108, 32'h0, 1, 0);
        checkOutput("lbu_wd_k", RF_wd, 32'h0000_0080);
        applyStimulus("lh", 32'h8409_0000, 32'h12, 32'h0, 32'h8001_0000, 32'h10C, 32'h0, 1, 0);
        checkOutput("lh_wd_k", RF_wd, 32'hFFFF_8001);
        applyStimulus("jal", 32'h0C00_0040, 32'h55, 32'h0, 32'h0, 32'h0000_300C, 32'h0, 1, 0);
        checkOutput("jal_wa_k", 32'(RF_wa), 32'd31);
        checkOutput("jal_wd_k", RF_wd, 32'h0000_300C);
        applyStimulus("addu0", 32'h0022_0021, 32'h77, 32'h0, 32'h0, 32'h110, 32'h0, 1, 0);
        checkOutput("addu0_we_k", 32'(RF_we), 32'd0);

        applyStimulus("ori", 32'h3405_1234, 32'h1234, 32'h0, 32'h0, 32'h114, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall", randInstr(), $urandom, $urandom, $urandom, $urandom, $urandom, 0, 0);
        checkOutput("stall_wd_k", RF_wd, 32'h1234);
        applyStimulus("flush", randInstr(), $urandom, $urandom, $urandom, $urandom, $urandom, 0, 1);
        checkOutput("flush_valid_k", 32'(valid_W), 32'd0);
        applyStimulus("flush_en", 32'h8C08_0004, 32'h10, 0, 32'h1, 32'h4, 0, 1, 1);

        applyStimulus("lw2", 32'h8C08_0004, 32'h10, 32'h0, 32'hCAFE_F00D, 32'h118, 32'h0, 1, 0);
        en = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_we", 32'(RF_we), 32'd0);
        checkOutput("arst_valid", 32'(valid_W), 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 600; i++)
            applyStimulus("rand", randInstr(), $urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
